// File: rtl/tc_bcd_display_out_if.sv
// Load/result bus between the calculator datapath and the display output unit.
interface tc_bcd_display_out_if #(
  parameter int N = 8
);
  logic         LOAD;
  logic [N-1:0] BinTC;
  logic         BUSY;
  logic         DONE;
  logic [6:0]   HEX3;
  logic [6:0]   HEX2;
  logic [6:0]   HEX1;
  logic [6:0]   HEX0;

  modport master (
    output LOAD, BinTC,
    input  BUSY, DONE, HEX3, HEX2, HEX1, HEX0
  );

  modport slave (
    input  LOAD, BinTC,
    output BUSY, DONE, HEX3, HEX2, HEX1, HEX0
  );
endinterface

// File: rtl/tc_bcd_display_out.sv
// Two's complement -> sign/magnitude -> serial BCD -> active-low 7-seg.
// Optional leading-zero blanking: define TC_BCD_DISPLAY_LZB_EN.
module tc_bcd_display_out #(
  parameter int N = 8
) (
  input logic                 CLK,
  input logic                 CLR,
  tc_bcd_display_out_if.slave bus
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    UPDATE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            sign;
  logic [N-1:0]    mag;
  logic [11:0]     bcd;
  logic [11:0]     bcd_adj;
  logic [CW-1:0]   cnt;
  logic [N+11:0]   sh;

  function automatic logic [3:0] adj(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  function automatic logic [6:0] seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign bcd_adj = {adj(bcd[11:8]), adj(bcd[7:4]), adj(bcd[3:0])};
  assign sh      = {bcd_adj, mag} << 1;
  assign bus.BUSY = (state != IDLE);

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.LOAD) state_nxt = CONVERT;
      CONVERT: if (cnt == CW'(N - 1)) state_nxt = UPDATE;
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      sign     <= 1'b0;
      mag      <= '0;
      bcd      <= '0;
      cnt      <= '0;
      bus.DONE <= 1'b0;
      bus.HEX3 <= 7'h7F;
      bus.HEX2 <= 7'h7F;
      bus.HEX1 <= 7'h7F;
      bus.HEX0 <= 7'h7F;
    end else begin
      bus.DONE <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.LOAD) begin
            sign <= bus.BinTC[N-1];
            mag  <= bus.BinTC[N-1] ? (~bus.BinTC) + N'(1) : bus.BinTC;
            bcd  <= '0;
            cnt  <= '0;
          end
        end
        CONVERT: begin
          {bcd, mag} <= sh;
          cnt        <= cnt + CW'(1);
        end
        UPDATE: begin
          bus.DONE <= 1'b1;
          bus.HEX3 <= sign ? 7'h3F : 7'h7F;
          bus.HEX0 <= seg(bcd[3:0]);
`ifdef TC_BCD_DISPLAY_LZB_EN
          bus.HEX2 <= (bcd[11:8] == 4'd0) ? 7'h7F : seg(bcd[11:8]);
          bus.HEX1 <= (bcd[11:4] == 8'd0) ? 7'h7F : seg(bcd[7:4]);
`else
          bus.HEX2 <= seg(bcd[11:8]);
          bus.HEX1 <= seg(bcd[7:4]);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tc_bcd_display_out.sv
// Directed bench for tc_bcd_display_out (N=8).
// Expected segment codes are hand-computed; LZB variants guarded by macro.
module tb_tc_bcd_display_out;

  logic CLK;
  logic CLR;
  int   n_chk;
  int   n_fail;
  int   n;
  int   busy_cnt;
  int   done_cnt;
  int   t1;
  int   t2;

  tc_bcd_display_out_if #(.N(8)) bus ();

  tc_bcd_display_out #(.N(8)) dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic show(input string tag, input logic [6:0] h3,
                      input logic [6:0] h2, input logic [6:0] h1,
                      input logic [6:0] h0);
    check({tag, ".hex3"}, 32'(bus.HEX3), 32'(h3));
    check({tag, ".hex2"}, 32'(bus.HEX2), 32'(h2));
    check({tag, ".hex1"}, 32'(bus.HEX1), 32'(h1));
    check({tag, ".hex0"}, 32'(bus.HEX0), 32'(h0));
  endtask

  // Load v, wait for DONE, check latency, busy width and one-cycle pulse.
  task automatic convert(input string tag, input logic [7:0] v);
    @(negedge CLK);
    bus.LOAD  = 1'b1;
    bus.BinTC = v;
    @(negedge CLK);
    bus.LOAD  = 1'b0;
    bus.BinTC = 8'hA5;
    n = 0;
    busy_cnt = 0;
    while (!bus.DONE && n < 40) begin
      if (bus.BUSY) busy_cnt++;
      @(negedge CLK);
      n++;
    end
    check({tag, ".lat"}, n, 9);
    check({tag, ".busy"}, busy_cnt, 9);
    check({tag, ".busy_done"}, 32'(bus.BUSY), 0);
    @(negedge CLK);
    check({tag, ".pulse"}, 32'(bus.DONE), 0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    CLR       = 1'b0;
    bus.LOAD  = 1'b0;
    bus.BinTC = '0;
    repeat (2) @(negedge CLK);
    CLR = 1'b1;
    @(negedge CLK);
    show("rst", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    check("rst.busy", 32'(bus.BUSY), 0);
    check("rst.done", 32'(bus.DONE), 0);

    convert("p123", 8'h7B);
    show("p123", 7'h7F, 7'h79, 7'h24, 7'h30);

    convert("m128", 8'h80);
    show("m128", 7'h3F, 7'h79, 7'h24, 7'h00);

    convert("p5", 8'h05);
`ifdef TC_BCD_DISPLAY_LZB_EN
    show("p5", 7'h7F, 7'h7F, 7'h7F, 7'h12);
`else
    show("p5", 7'h7F, 7'h40, 7'h40, 7'h12);
`endif

    convert("zero", 8'h00);
`ifdef TC_BCD_DISPLAY_LZB_EN
    show("zero", 7'h7F, 7'h7F, 7'h7F, 7'h40);
`else
    show("zero", 7'h7F, 7'h40, 7'h40, 7'h40);
`endif

    // LOAD while busy is ignored; displays hold the zero result meanwhile
    @(negedge CLK);
    bus.LOAD  = 1'b1;
    bus.BinTC = 8'hFF;
    @(negedge CLK);
    bus.LOAD  = 1'b0;
    repeat (2) @(negedge CLK);
    bus.LOAD  = 1'b1;
    bus.BinTC = 8'h64;
    @(negedge CLK);
    bus.LOAD  = 1'b0;
    check("ign.hold0", 32'(bus.HEX0), 32'h40);
    check("ign.hold3", 32'(bus.HEX3), 32'h7F);
    done_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      if (bus.DONE) done_cnt++;
      @(negedge CLK);
    end
    check("ign.dones", done_cnt, 1);
`ifdef TC_BCD_DISPLAY_LZB_EN
    show("ign", 7'h3F, 7'h7F, 7'h7F, 7'h79);
`else
    show("ign", 7'h3F, 7'h40, 7'h40, 7'h79);
`endif

    // LOAD held high: conversions accepted every N+2 cycles
    @(negedge CLK);
    bus.LOAD  = 1'b1;
    bus.BinTC = 8'h01;
    t1 = -1;
    t2 = -1;
    for (int i = 0; i < 40 && t2 < 0; i++) begin
      @(negedge CLK);
      if (bus.DONE) begin
        if (t1 < 0) t1 = i;
        else        t2 = i;
      end
    end
    bus.LOAD = 1'b0;
    check("hold.gap", t2 - t1, 10);
    repeat (12) @(negedge CLK);

    // Abort mid-conversion with CLR
    convert("pre", 8'h7B);
    @(negedge CLK);
    bus.LOAD  = 1'b1;
    bus.BinTC = 8'h9C;
    @(negedge CLK);
    bus.LOAD  = 1'b0;
    repeat (3) @(negedge CLK);
    check("abort.busy_pre", 32'(bus.BUSY), 1);
    CLR = 1'b0;
    #1;
    show("abort", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    check("abort.busy", 32'(bus.BUSY), 0);
    @(negedge CLK);
    CLR = 1'b1;
    convert("m100", 8'h9C);
    show("m100", 7'h3F, 7'h79, 7'h40, 7'h40);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
